// File: rtl/bpc_rr_scheduler_if.sv
// Handshake bundle between the round-robin scheduler, its requesters, the shared
// population counter and the response consumer.
interface bpc_rr_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  localparam int IDW = $clog2(N_REQ);
  localparam int RW  = $clog2(WIDTH) + 1;

  logic [N_REQ-1:0]       req_val_i;
  logic [N_REQ*WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic [WIDTH-1:0]       cnt_data_o;
  logic                   cnt_val_o;
  logic [RW-1:0]          cnt_data_i;
  logic                   cnt_val_i;
  logic                   resp_val_o;
  logic [IDW-1:0]         resp_id_o;
  logic [RW-1:0]          resp_data_o;
  logic                   resp_err_o;

  modport slave (
    input  req_val_i, req_data_i, cnt_data_i, cnt_val_i,
    output req_ready_o, cnt_data_o, cnt_val_o,
    output resp_val_o, resp_id_o, resp_data_o, resp_err_o
  );

  modport master (
    output req_val_i, req_data_i, cnt_data_i, cnt_val_i,
    input  req_ready_o, cnt_data_o, cnt_val_o,
    input  resp_val_o, resp_id_o, resp_data_o, resp_err_o
  );
endinterface

// File: rtl/bpc_rr_scheduler.sv
// Round-robin front end sharing one population counter between N_REQ clients,
// one operation in flight, with a timeout error response.
//
// state  | meaning
// S_IDLE | scanning requesters from the rr pointer, accept on any valid
// S_WAIT | word issued to counter, waiting for result or timeout
// S_RESP | one-cycle tagged response to the client side
module bpc_rr_scheduler #(
  parameter int WIDTH   = 8,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  bpc_rr_scheduler_if.slave   bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int RW  = $clog2(WIDTH) + 1;
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] cnt_data_q, cnt_data_d;
  logic             cnt_val_q, cnt_val_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [RW-1:0]    resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;

  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   idx;
  logic             any_val;
  logic [N_REQ-1:0] ready;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_val = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr_q) + i) % N_REQ);
      if (bus.req_val_i[idx]) begin
        grant   = idx;
        any_val = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_data_d  = cnt_data_q;
    cnt_val_d   = 1'b0;
    tmr_d       = tmr_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    ready       = '0;
    case (state_q)
      S_IDLE: begin
        if (any_val) begin
          ready      = N_REQ'(1) << grant;
          cnt_data_d = bus.req_data_i[int'(grant)*WIDTH +: WIDTH];
          cnt_val_d  = 1'b1;
          id_d       = grant;
          ptr_d      = (int'(grant) == N_REQ - 1) ? '0 : grant + IDW'(1);
          tmr_d      = TW'(TIMEOUT - 1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result arriving on the terminal-count cycle still wins over the timeout.
        if (bus.cnt_val_i) begin
          resp_id_d   = id_q;
          resp_data_d = bus.cnt_data_i;
          resp_err_d  = 1'b0;
          state_d     = S_RESP;
        end else if (tmr_q == '0) begin
          resp_id_d   = id_q;
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = S_RESP;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_data_q  <= '0;
      cnt_val_q   <= 1'b0;
      tmr_q       <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_data_q  <= cnt_data_d;
      cnt_val_q   <= cnt_val_d;
      tmr_q       <= tmr_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Grant strobe is combinational, so mask it while reset is held.
  assign bus.req_ready_o = arstn_i ? ready : '0;
  assign bus.cnt_data_o  = cnt_data_q;
  assign bus.cnt_val_o   = cnt_val_q;
  assign bus.resp_val_o  = (state_q == S_RESP);
  assign bus.resp_id_o   = resp_id_q;
  assign bus.resp_data_o = resp_data_q;
  assign bus.resp_err_o  = resp_err_q;
endmodule

// File: tb/tb_bpc_rr_scheduler.sv
// Randomized and directed bench for bpc_rr_scheduler with a latency-2 counter model
// and a transaction-level scoreboard.
module tb_bpc_rr_scheduler;
  localparam int WIDTH   = 8;
  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 64;
  localparam int RW      = $clog2(WIDTH) + 1;

  typedef struct {
    int id;
    int data;
    int err;
    int cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic arstn = 1'b0;
  logic mute  = 1'b0;
  logic spur  = 1'b0;
  logic reraise  = 1'b0;
  logic rnd_mode = 1'b0;
  logic [N_REQ-1:0] last_rdy = '0;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int model_free  = 0;
  int model_ptr   = 0;
  int exp_cnt_cyc = -1;
  logic [WIDTH-1:0] exp_cnt_data = '0;
  exp_t q[$];

  always #5 clk = ~clk;

  bpc_rr_scheduler_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  bpc_rr_scheduler #(.WIDTH(WIDTH), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (bus)
  );

  // Shared counter model: fixed latency of two cycles, can be muted to force a timeout.
  logic [1:0]    pv;
  logic [RW-1:0] pd0, pd1;
  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      pv <= '0; pd0 <= '0; pd1 <= '0;
    end else begin
      pv[0] <= bus.cnt_val_o & ~mute;
      pv[1] <= pv[0];
      pd0   <= RW'($countones(bus.cnt_data_o));
      pd1   <= pd0;
    end
  end
  assign bus.cnt_val_i  = pv[1] | spur;
  assign bus.cnt_data_i = spur ? RW'(3) : pd1;

  function automatic int ref_pop(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int b = 0; b < WIDTH; b++) if (w[b]) n = n + 1;
    return n;
  endfunction

  function automatic int pick_grant(input logic [N_REQ-1:0] v, input int p);
    for (int i = 0; i < N_REQ; i++) if (v[(p + i) % N_REQ]) return (p + i) % N_REQ;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [N_REQ-1:0] exp_rdy;
    logic             exp_resp;
    int               g;
    exp_t             e;
    cyc++;
    if (!arstn) begin
      check("rst_outputs", {bus.req_ready_o, bus.cnt_val_o, bus.cnt_data_o, bus.resp_val_o,
                            bus.resp_id_o, bus.resp_data_o, bus.resp_err_o}, 64'd0);
      q.delete();
      model_free  = 0;
      model_ptr   = 0;
      exp_cnt_cyc = -1;
    end else begin
      exp_rdy = '0;
      if (cyc >= model_free && |bus.req_val_i) begin
        g = pick_grant(bus.req_val_i, model_ptr);
        exp_rdy = N_REQ'(1) << g;
        e.id   = g;
        e.err  = mute ? 1 : 0;
        e.data = mute ? 0 : ref_pop(bus.req_data_i[g*WIDTH +: WIDTH]);
        e.cyc  = mute ? cyc + 1 + TIMEOUT : cyc + 4;
        q.push_back(e);
        exp_cnt_cyc  = cyc + 1;
        exp_cnt_data = bus.req_data_i[g*WIDTH +: WIDTH];
        model_free   = mute ? cyc + TIMEOUT + 2 : cyc + 5;
        model_ptr    = (g + 1) % N_REQ;
      end
      check("req_ready", bus.req_ready_o, exp_rdy);
      check("cnt_val", bus.cnt_val_o, cyc == exp_cnt_cyc);
      if (cyc == exp_cnt_cyc) check("cnt_data", bus.cnt_data_o, exp_cnt_data);
      exp_resp = (q.size() > 0) && (q[0].cyc == cyc);
      check("resp_val", bus.resp_val_o, exp_resp);
      if (exp_resp) begin
        e = q.pop_front();
        check("resp_id", bus.resp_id_o, e.id);
        check("resp_data", bus.resp_data_o, e.data);
        check("resp_err", bus.resp_err_o, e.err);
      end
    end
  end

  // One cycle of requester behaviour: hold until granted, then drop (or re-raise).
  task automatic step();
    logic [N_REQ-1:0] rdy;
    @(negedge clk);
    rdy = bus.req_ready_o;
    last_rdy = rdy;
    @(posedge clk);
    #1;
    for (int k = 0; k < N_REQ; k++) begin
      if (rdy[k]) begin
        if (!reraise) bus.req_val_i[k] = 1'b0;
      end else if (rnd_mode) begin
        if (!bus.req_val_i[k] && $urandom_range(99) < 30) begin
          bus.req_val_i[k] = 1'b1;
          bus.req_data_i[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        end else if (bus.req_val_i[k] && $urandom_range(99) < 4) begin
          bus.req_val_i[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((q.size() != 0 || cyc < model_free || |bus.req_val_i) && n < budget) begin
      step();
      n++;
    end
    check("idle_reached", n < budget, 1'b1);
  endtask

  task automatic issue(input int k, input logic [WIDTH-1:0] w);
    bus.req_data_i[k*WIDTH +: WIDTH] = w;
    bus.req_val_i[k] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_val_i  = '0;
    bus.req_data_i = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    arstn = 1'b1;

    // All four requesters continuously valid: grants rotate 0,1,2,3,0.
    reraise = 1'b1;
    issue(0, 8'hFF); issue(1, 8'h00); issue(2, 8'h0F); issue(3, 8'h81);
    repeat (26) step();
    reraise = 1'b0;
    bus.req_val_i = '0;
    wait_idle(50);

    // Single requester 2, then wrap from pointer 3 to requester 1.
    issue(2, 8'hB5);
    wait_idle(50);
    issue(1, 8'h3C);
    wait_idle(50);
    issue(1, 8'h11); issue(2, 8'h22); issue(3, 8'h33);
    wait_idle(80);

    // Extreme words.
    issue(0, 8'h00);
    wait_idle(50);
    issue(3, 8'hFF);
    wait_idle(50);

    // Counter never answers, then a normal request.
    mute = 1'b1;
    issue(1, 8'h77);
    wait_idle(150);
    mute = 1'b0;
    issue(1, 8'h77);
    wait_idle(50);

    // Spurious counter strobes while idle must be dropped.
    repeat (3) begin
      spur = 1'b1; step(); spur = 1'b0; step();
    end

    // Reset in the middle of an operation.
    issue(0, 8'hAA);
    n = 0;
    do begin step(); n++; end while (!last_rdy[0] && n < 10);
    check("reset_test_accept", last_rdy[0], 1'b1);
    step();
    bus.req_val_i = '0;
    arstn = 1'b0;
    #1;
    check("rst_async", {bus.req_ready_o, bus.cnt_val_o, bus.cnt_data_o, bus.resp_val_o,
                        bus.resp_id_o, bus.resp_data_o, bus.resp_err_o}, 64'd0);
    repeat (2) step();
    arstn = 1'b1;
    repeat (20) step();

    // Random traffic with drops.
    rnd_mode = 1'b1;
    repeat (600) step();
    rnd_mode = 1'b0;
    bus.req_val_i = '0;
    wait_idle(200);

    check("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
